regfile_dbg_ctrl: RTL and testbench
===================================

# regfile_dbg_ctrl

Debug-access controller for the integer register file. Owns the register file write port, merging core writeback with debug (JTAG-side) read and write requests. Sits between the core writeback stage, the debug transport and the register file. Core writeback always has priority. Optional starvation relief stalls the core so a pending debug write can complete.

## Interface
Parameters:
- STARVE_LIMIT, 8: consecutive blocked cycles before the core is stalled; legal range 1..255.
- XLEN, 32: data width.

Ports:
- clk  in  1  system clock; single clock domain.
- rst_n  in  1  asynchronous, active-low reset.
- core_wr_en_i  in  1  core writeback valid.
- core_wr_add_i  in  5  core writeback register index.
- core_wr_data_i  in  XLEN  core writeback data.
- core_stall_o  out  1  request to the core to withhold writeback.
- dbg_req_valid_i  in  1  debug request valid.
- dbg_req_ready_o  out  1  debug request accepted.
- dbg_req_we_i  in  1  1 = write, 0 = read.
- dbg_req_add_i  in  5  debug register index.
- dbg_req_data_i  in  XLEN  debug write data.
- dbg_rsp_valid_o  out  1  response valid.
- dbg_rsp_ready_i  in  1  response consumed.
- dbg_rsp_data_o  out  XLEN  read data; 0 for writes.
- dbg_rsp_err_o  out  1  write to x0 was rejected.
- rf_wr_en_o  out  1  register file write enable.
- rf_wr_add_o  out  5  register file write index.
- rf_wr_data_o  out  XLEN  register file write data.
- rf_rd_add_o  out  5  register file debug read index.
- rf_rd_data_i  in  XLEN  register file debug read data. This path is combinational and includes write bypass.

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE: dbg_req_ready_o = 1. On valid && ready, latch we/add/data and go to ACCESS.
- ACCESS, read: rf_rd_add_o = latched add. Capture rf_rd_data_i into the response register. Go to RESP. Reads never wait.
- ACCESS, write to x0: no write is issued. Set rsp_err = 1 and go to RESP.
- ACCESS, write, core_wr_en_i = 0: drive rf_wr_* from the latched request. Set rsp_data = 0, err = 0. Go to RESP.
- ACCESS, write, core_wr_en_i = 1: the core write goes through. Stay in ACCESS and increment the blocked counter.
- RESP: dbg_rsp_valid_o = 1 and its payload is held stable until dbg_rsp_ready_i = 1, then go to IDLE.
- Write-port mux: rf_wr_* = core_wr_* whenever core_wr_en_i = 1; otherwise the debug write in ACCESS; otherwise rf_wr_en_o = 0.
- Core write while a debug read is in ACCESS: the read returns the new data through the register file bypass.
- Blocked counter: saturating, 8 bits. Cleared when leaving ACCESS.
- Reset mid-operation: go to IDLE immediately. Any pending request or response is dropped and no write is issued.

## Timing
- Reset values:
  - dbg_req_ready_o = 0 while rst_n = 0, then 1 once in IDLE.
  - dbg_rsp_valid_o = 0, dbg_rsp_data_o = 0, dbg_rsp_err_o = 0.
  - core_stall_o = 0, rf_wr_en_o = 0.
  - rf_wr_add_o = 0, rf_wr_data_o = 0, rf_rd_add_o = 0.
- Latency: request accepted in cycle 0, register file access in cycle 1, dbg_rsp_valid_o high from cycle 2. A write waits one extra cycle for each blocked ACCESS cycle.
- Back-to-back requests: a new request can be accepted no earlier than the cycle after the response handshake (RESP to IDLE).
- The core path is combinational (zero added latency). rf_wr_* for a debug write is decoded from registered state.

## Configuration
- REGFILE_DBG_STARVE_EN defined:
  - core_stall_o is registered and rises the cycle after the counter reaches STARVE_LIMIT.
  - It stays high until the debug write issues, then falls in the RESP entry cycle.
  - The core must deassert core_wr_en_i the cycle after it sees core_stall_o.
- REGFILE_DBG_STARVE_EN undefined: core_stall_o is tied to 0 and the counter is not built. A debug write waits indefinitely while the core keeps writing.

## Structure
- Package regfile_dbg_pkg holds the state enum (IDLE/ACCESS/RESP), REG_ADDR_W = 5 and the default XLEN.
- Sub-module regfile_dbg_starve_cnt holds the blocked counter, limit compare and stall register. It is instantiated only under REGFILE_DBG_STARVE_EN.

## Test plan
- Debug write x5 = 0xDEADBEEF with the core idle: rf_wr_en_o pulses in cycle 1 with add 5, response in cycle 2 with err = 0. A following read of x5 returns 0xDEADBEEF.
- Debug write x0 = 0x1234: rf_wr_en_o never asserts, dbg_rsp_err_o = 1, and reading x0 returns 0.
- Core writes x7 = 0xA5A5A5A5 in the same cycle a debug read of x7 is in ACCESS: the response data is 0xA5A5A5A5.
- Core writes every cycle during a debug write to x3, with STARVE_LIMIT = 4:
  - Macro defined: core_stall_o rises after 4 blocked cycles, the write issues the cycle after the core stops, and the stall then clears.
  - Macro undefined: no response until the core idles.
- Response held with dbg_rsp_ready_i = 0 for 5 cycles: valid, data and err stay stable, and dbg_req_ready_o stays 0.
- rst_n asserted during ACCESS of a pending write: no rf_wr_en_o pulse, and all outputs go to their reset values asynchronously.

Source files
------------

// File: rtl/regfile_dbg_pkg.sv
// Shared types and constants for the register-file debug-access controller.
package regfile_dbg_pkg;

  localparam int unsigned REG_ADDR_W   = 5;
  localparam int unsigned XLEN_DEFAULT = 32;
  localparam int unsigned STARVE_CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

endpackage

// File: rtl/regfile_dbg_starve_cnt.sv
// Blocked-cycle counter and registered core stall request for debug-write starvation relief.
module regfile_dbg_starve_cnt
  import regfile_dbg_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_blocked,
  input  logic i_clear,
  output logic o_stall
);

  localparam logic [STARVE_CNT_W-1:0] LIMIT = STARVE_CNT_W'(STARVE_LIMIT);

  logic [STARVE_CNT_W-1:0] r_cnt;
  logic                    r_stall;

  // Stall is judged on the registered count, so it rises one cycle after the limit is reached.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_stall <= 1'b0;
    end else if (i_clear) begin
      r_cnt   <= '0;
      r_stall <= 1'b0;
    end else begin
      if (i_blocked && (r_cnt != '1)) begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (r_cnt >= LIMIT) begin
        r_stall <= 1'b1;
      end
    end
  end

  assign o_stall = r_stall;

endmodule

// File: rtl/regfile_dbg_ctrl.sv
// Merges core writeback with debug read/write requests on the register file ports.
// Core stall for starved debug writes is built only when REGFILE_DBG_STARVE_EN is defined.
module regfile_dbg_ctrl
  import regfile_dbg_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 8,
  parameter int unsigned XLEN         = XLEN_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  core_wr_en_i,
  input  logic [REG_ADDR_W-1:0] core_wr_add_i,
  input  logic [XLEN-1:0]       core_wr_data_i,
  output logic                  core_stall_o,
  input  logic                  dbg_req_valid_i,
  output logic                  dbg_req_ready_o,
  input  logic                  dbg_req_we_i,
  input  logic [REG_ADDR_W-1:0] dbg_req_add_i,
  input  logic [XLEN-1:0]       dbg_req_data_i,
  output logic                  dbg_rsp_valid_o,
  input  logic                  dbg_rsp_ready_i,
  output logic [XLEN-1:0]       dbg_rsp_data_o,
  output logic                  dbg_rsp_err_o,
  output logic                  rf_wr_en_o,
  output logic [REG_ADDR_W-1:0] rf_wr_add_o,
  output logic [XLEN-1:0]       rf_wr_data_o,
  output logic [REG_ADDR_W-1:0] rf_rd_add_o,
  input  logic [XLEN-1:0]       rf_rd_data_i
);

  if ((STARVE_LIMIT < 1) || (STARVE_LIMIT > 255)) begin : g_bad_limit
    $error("STARVE_LIMIT must be within 1..255");
  end

  state_e                r_state;
  logic                  r_req_ready;
  logic                  r_rsp_valid;
  logic                  r_rsp_err;
  logic [XLEN-1:0]       r_rsp_data;
  logic                  r_we;
  logic [REG_ADDR_W-1:0] r_add;
  logic [XLEN-1:0]       r_wdata;

  logic w_dbg_wr_pend;
  logic w_dbg_wr;
  logic w_leave_access;

  // A non-x0 debug write is the only access that can be held off by the core.
  assign w_dbg_wr_pend  = (r_state == ACCESS) && r_we && (r_add != '0);
  assign w_dbg_wr       = w_dbg_wr_pend && !core_wr_en_i;
  assign w_leave_access = (r_state == ACCESS) && !(w_dbg_wr_pend && core_wr_en_i);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_req_ready <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_data  <= '0;
      r_we        <= 1'b0;
      r_add       <= '0;
      r_wdata     <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (dbg_req_valid_i && r_req_ready) begin
            r_we        <= dbg_req_we_i;
            r_add       <= dbg_req_add_i;
            r_wdata     <= dbg_req_data_i;
            r_req_ready <= 1'b0;
            r_state     <= ACCESS;
          end else begin
            r_req_ready <= 1'b1;
          end
        end
        ACCESS: begin
          if (w_leave_access) begin
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= r_we && (r_add == '0);
            r_rsp_data  <= r_we ? '0 : rf_rd_data_i;
            r_state     <= RESP;
          end
        end
        RESP: begin
          if (dbg_rsp_ready_i) begin
            r_rsp_valid <= 1'b0;
            r_req_ready <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_comb begin
    rf_wr_en_o   = 1'b0;
    rf_wr_add_o  = '0;
    rf_wr_data_o = '0;
    if (core_wr_en_i) begin
      rf_wr_en_o   = 1'b1;
      rf_wr_add_o  = core_wr_add_i;
      rf_wr_data_o = core_wr_data_i;
    end else if (w_dbg_wr) begin
      rf_wr_en_o   = 1'b1;
      rf_wr_add_o  = r_add;
      rf_wr_data_o = r_wdata;
    end
  end

  assign rf_rd_add_o     = r_add;
  assign dbg_req_ready_o = r_req_ready;
  assign dbg_rsp_valid_o = r_rsp_valid;
  assign dbg_rsp_data_o  = r_rsp_data;
  assign dbg_rsp_err_o   = r_rsp_err;

`ifdef REGFILE_DBG_STARVE_EN
  regfile_dbg_starve_cnt #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_starve_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_blocked(w_dbg_wr_pend && core_wr_en_i),
    .i_clear  (w_leave_access),
    .o_stall  (core_stall_o)
  );
`else
  assign core_stall_o = 1'b0;
`endif

endmodule

// File: tb/tb_regfile_dbg_ctrl.sv
// Self-checking bench for regfile_dbg_ctrl: directed debug/core traffic against a register-file model.
module tb_regfile_dbg_ctrl;

  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        core_wr_en_i;
  logic [4:0]  core_wr_add_i;
  logic [31:0] core_wr_data_i;
  logic        core_stall_o;
  logic        dbg_req_valid_i;
  logic        dbg_req_ready_o;
  logic        dbg_req_we_i;
  logic [4:0]  dbg_req_add_i;
  logic [31:0] dbg_req_data_i;
  logic        dbg_rsp_valid_o;
  logic        dbg_rsp_ready_i;
  logic [31:0] dbg_rsp_data_o;
  logic        dbg_rsp_err_o;
  logic        rf_wr_en_o;
  logic [4:0]  rf_wr_add_o;
  logic [31:0] rf_wr_data_o;
  logic [4:0]  rf_rd_add_o;
  logic [31:0] rf_rd_data_i;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  regfile_dbg_ctrl #(
    .STARVE_LIMIT(LIMIT),
    .XLEN        (32)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .core_wr_en_i   (core_wr_en_i),
    .core_wr_add_i  (core_wr_add_i),
    .core_wr_data_i (core_wr_data_i),
    .core_stall_o   (core_stall_o),
    .dbg_req_valid_i(dbg_req_valid_i),
    .dbg_req_ready_o(dbg_req_ready_o),
    .dbg_req_we_i   (dbg_req_we_i),
    .dbg_req_add_i  (dbg_req_add_i),
    .dbg_req_data_i (dbg_req_data_i),
    .dbg_rsp_valid_o(dbg_rsp_valid_o),
    .dbg_rsp_ready_i(dbg_rsp_ready_i),
    .dbg_rsp_data_o (dbg_rsp_data_o),
    .dbg_rsp_err_o  (dbg_rsp_err_o),
    .rf_wr_en_o     (rf_wr_en_o),
    .rf_wr_add_o    (rf_wr_add_o),
    .rf_wr_data_o   (rf_wr_data_o),
    .rf_rd_add_o    (rf_rd_add_o),
    .rf_rd_data_i   (rf_rd_data_i)
  );

  // Register file environment: x0 hardwired, write bypass on the debug read port.
  logic [31:0] regs [32] = '{default: 32'h0};
  always @(posedge clk) begin
    if (rf_wr_en_o && (rf_wr_add_o != 5'd0)) regs[rf_wr_add_o] <= rf_wr_data_o;
  end
  always_comb begin
    rf_rd_data_i = regs[rf_rd_add_o];
    if (rf_rd_add_o == 5'd0) rf_rd_data_i = 32'h0;
    else if (rf_wr_en_o && (rf_wr_add_o == rf_rd_add_o)) rf_rd_data_i = rf_wr_data_o;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: phase of the outstanding request plus a golden register array.
  int          m_phase = 0;  // 0 free, 1 accessing, 2 responding
  bit          m_up = 1'b0;
  bit          m_we;
  logic [4:0]  m_add;
  logic [31:0] m_data;
  logic [31:0] m_rsp_data;
  bit          m_rsp_err;
  int          m_blk = 0;
  logic [31:0] m_regs [32] = '{default: 32'h0};
  bit          e_pend, e_ready, e_wr_en, e_stall;
  logic [4:0]  e_wr_add;
  logic [31:0] e_wr_data;

  always @(negedge clk) begin
    if (!rst_n) begin
      check("rst_req_ready", dbg_req_ready_o, 0);
      check("rst_rsp_valid", dbg_rsp_valid_o, 0);
      check("rst_rsp_data", dbg_rsp_data_o, 0);
      check("rst_rsp_err", dbg_rsp_err_o, 0);
      check("rst_stall", core_stall_o, 0);
      check("rst_wr_en", rf_wr_en_o, 0);
      check("rst_wr_add", rf_wr_add_o, 0);
      check("rst_wr_data", rf_wr_data_o, 0);
      check("rst_rd_add", rf_rd_add_o, 0);
      m_phase = 0;
      m_up    = 1'b0;
      m_blk   = 0;
    end else begin
      e_pend  = (m_phase == 1) && m_we && (m_add != 5'd0);
      e_ready = m_up && (m_phase == 0);
      check("req_ready", dbg_req_ready_o, e_ready);
      check("rsp_valid", dbg_rsp_valid_o, m_phase == 2);
      if (m_phase == 2) begin
        check("rsp_data", dbg_rsp_data_o, m_rsp_data);
        check("rsp_err", dbg_rsp_err_o, m_rsp_err);
      end
      if ((m_phase == 1) && !m_we) check("rd_add", rf_rd_add_o, m_add);
      e_wr_en = 1'b0;
      e_wr_add = 5'd0;
      e_wr_data = 32'h0;
      if (core_wr_en_i) begin
        e_wr_en = 1'b1; e_wr_add = core_wr_add_i; e_wr_data = core_wr_data_i;
      end else if (e_pend) begin
        e_wr_en = 1'b1; e_wr_add = m_add; e_wr_data = m_data;
      end
      check("wr_en", rf_wr_en_o, e_wr_en);
      if (e_wr_en) begin
        check("wr_add", rf_wr_add_o, e_wr_add);
        check("wr_data", rf_wr_data_o, e_wr_data);
      end
`ifdef REGFILE_DBG_STARVE_EN
      // Registered stall: visible once more than LIMIT blocked cycles have elapsed.
      e_stall = e_pend && (m_blk > LIMIT);
`else
      e_stall = 1'b0;
`endif
      check("stall", core_stall_o, e_stall);

      case (m_phase)
        0: if (dbg_req_valid_i && e_ready) begin
          m_we = dbg_req_we_i; m_add = dbg_req_add_i; m_data = dbg_req_data_i;
          m_blk = 0; m_phase = 1;
        end
        1: if (e_pend && core_wr_en_i) begin
          m_blk++;
        end else begin
          m_rsp_err = m_we && (m_add == 5'd0);
          if (m_we) begin
            m_rsp_data = 32'h0;
            if (m_add != 5'd0) m_regs[m_add] = m_data;
          end else if (m_add == 5'd0) m_rsp_data = 32'h0;
          else if (core_wr_en_i && (core_wr_add_i == m_add)) m_rsp_data = core_wr_data_i;
          else m_rsp_data = m_regs[m_add];
          m_phase = 2;
        end
        2: if (dbg_rsp_ready_i) m_phase = 0;
        default: m_phase = 0;
      endcase
      if (core_wr_en_i && (core_wr_add_i != 5'd0)) m_regs[core_wr_add_i] = core_wr_data_i;
      m_up = 1'b1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a request and return in the first cycle after acceptance.
  task automatic start_req(input bit we, input logic [4:0] add, input logic [31:0] data);
    int n = 0;
    dbg_req_valid_i = 1'b1;
    dbg_req_we_i    = we;
    dbg_req_add_i   = add;
    dbg_req_data_i  = data;
    while (!dbg_req_ready_o && (n < 50)) begin
      step();
      n++;
    end
    check("req_accept_timeout", n < 50, 1);
    step();
    dbg_req_valid_i = 1'b0;
  endtask

  task automatic finish_rsp(output logic [31:0] d, output logic e, output int lat);
    lat = 1;
    while (!dbg_rsp_valid_o && (lat < 200)) begin
      step();
      lat++;
    end
    check("rsp_timeout", lat < 200, 1);
    d = dbg_rsp_data_o;
    e = dbg_rsp_err_o;
    dbg_rsp_ready_i = 1'b1;
    step();
  endtask

  task automatic core_wr(input logic [4:0] add, input logic [31:0] data);
    core_wr_en_i = 1'b1; core_wr_add_i = add; core_wr_data_i = data;
    step();
    core_wr_en_i = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    logic [31:0] d;
    logic        e;
    int          lat;
    int          c;
    int          first_stall;
    bit          stall_seen;

    rst_n = 1'b0;
    core_wr_en_i = 1'b0; core_wr_add_i = '0; core_wr_data_i = '0;
    dbg_req_valid_i = 1'b0; dbg_req_we_i = 1'b0; dbg_req_add_i = '0; dbg_req_data_i = '0;
    dbg_rsp_ready_i = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Debug write x5 with the core idle, then read it back.
    start_req(1'b1, 5'd5, 32'hDEADBEEF);
    check("t1_cyc1_wr_en", rf_wr_en_o, 1);
    check("t1_cyc1_wr_add", rf_wr_add_o, 5);
    check("t1_cyc1_wr_data", rf_wr_data_o, 32'hDEADBEEF);
    finish_rsp(d, e, lat);
    check("t1_latency", lat, 2);
    check("t1_err", e, 0);
    check("t1_data", d, 0);
    start_req(1'b0, 5'd5, 32'h0);
    finish_rsp(d, e, lat);
    check("t2_rd_x5", d, 32'hDEADBEEF);
    check("t2_latency", lat, 2);

    // Write to x0 is rejected; x0 reads as zero.
    start_req(1'b1, 5'd0, 32'h1234);
    check("t3_no_wr", rf_wr_en_o, 0);
    finish_rsp(d, e, lat);
    check("t3_err", e, 1);
    start_req(1'b0, 5'd0, 32'h0);
    finish_rsp(d, e, lat);
    check("t3_rd_x0", d, 0);
    check("t3_rd_err", e, 0);

    // Core write to x7 in the same cycle a debug read of x7 is accessing.
    core_wr(5'd7, 32'h11111111);
    start_req(1'b0, 5'd7, 32'h0);
    core_wr_en_i = 1'b1; core_wr_add_i = 5'd7; core_wr_data_i = 32'hA5A5A5A5;
    step();
    core_wr_en_i = 1'b0;
    finish_rsp(d, e, lat);
    check("t4_bypass", d, 32'hA5A5A5A5);

    // Core writes every cycle during a debug write to x3.
    start_req(1'b1, 5'd3, 32'hCAFE0003);
    c = 0; first_stall = -1; stall_seen = 1'b0;
    while (!dbg_rsp_valid_o && (c < 60)) begin
`ifdef REGFILE_DBG_STARVE_EN
      core_wr_en_i = !stall_seen;
`else
      core_wr_en_i = (c < 10);
`endif
      core_wr_add_i = 5'd10; core_wr_data_i = 32'(c);
      stall_seen = core_stall_o;
      if (core_stall_o && (first_stall < 0)) first_stall = c;
      step();
      c++;
    end
    core_wr_en_i = 1'b0;
`ifdef REGFILE_DBG_STARVE_EN
    check("t5_rsp_cycle", c, 7);
    check("t5_first_stall", first_stall, 5);
`else
    check("t5_rsp_cycle", c, 11);
    check("t5_no_stall", first_stall, -1);
`endif
    check("t5_stall_cleared", core_stall_o, 0);
    finish_rsp(d, e, lat);
    check("t5_err", e, 0);
    start_req(1'b0, 5'd3, 32'h0);
    finish_rsp(d, e, lat);
    check("t5_rd_x3", d, 32'hCAFE0003);

    // Response held for 5 cycles by the consumer.
    dbg_rsp_ready_i = 1'b0;
    start_req(1'b0, 5'd5, 32'h0);
    step();
    for (int i = 0; i < 5; i++) begin
      check("t6_hold_valid", dbg_rsp_valid_o, 1);
      check("t6_hold_data", dbg_rsp_data_o, 32'hDEADBEEF);
      check("t6_hold_err", dbg_rsp_err_o, 0);
      check("t6_hold_req_ready", dbg_req_ready_o, 0);
      step();
    end
    dbg_rsp_ready_i = 1'b1;
    step();
    check("t6_ready_after", dbg_req_ready_o, 1);

    // Reset while a debug write to x9 is blocked in access.
    core_wr_en_i = 1'b1; core_wr_add_i = 5'd12; core_wr_data_i = 32'h12121212;
    start_req(1'b1, 5'd9, 32'h99999999);
    rst_n = 1'b0;
    #1;
    core_wr_en_i = 1'b0;
    #1;
    check("t7_async_wr_en", rf_wr_en_o, 0);
    check("t7_async_req_ready", dbg_req_ready_o, 0);
    check("t7_async_rsp_valid", dbg_rsp_valid_o, 0);
    check("t7_async_rd_add", rf_rd_add_o, 0);
    step();
    step();
    rst_n = 1'b1;
    start_req(1'b0, 5'd9, 32'h0);
    finish_rsp(d, e, lat);
    check("t7_x9_unwritten", d, 0);
    check("t7_x9_regfile", regs[9], 0);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
